// File: rtl/fixed_point_divider.sv
// Signed fixed-point divider: quotient = (dividend << F) / divisor, radix-2 restoring,
// one operation in flight, saturating result with divide-by-zero and overflow flags.
package ransac_fixed;
    localparam int integer_bits  = 16;
    localparam int fraction_bits = 16;
    typedef logic signed [integer_bits+fraction_bits-1:0] fixed_t;
    function automatic int value_bits();
        return integer_bits + fraction_bits;
    endfunction
endpackage

module fixed_point_divider #(
    parameter type external_pipeline = logic
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  ransac_fixed::fixed_t  dividend,
    input  ransac_fixed::fixed_t  divisor,
    input  external_pipeline      pipeline_i,
    output ransac_fixed::fixed_t  quotient,
    output logic                  done,
    output logic                  divide_by_zero,
    output logic                  overflow,
    output external_pipeline      pipeline_o
);
    import ransac_fixed::*;

    localparam int V  = ransac_fixed::value_bits();
    localparam int F  = ransac_fixed::fraction_bits;
    localparam int N  = V + F;
    localparam int CW = $clog2(N + 1);

    localparam fixed_t         MAX_Q   = {1'b0, {(V-1){1'b1}}};
    localparam fixed_t         MIN_Q   = {1'b1, {(V-1){1'b0}}};
    localparam logic [N-1:0]   POS_LIM = {{(N-V+1){1'b0}}, {(V-1){1'b1}}};
    localparam logic [N-1:0]   NEG_LIM = {{(N-V){1'b0}}, 1'b1, {(V-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SETUP, DIVIDE, FINISH} state_t;

    state_t           state;
    fixed_t           a_q, b_q;
    external_pipeline tag_q;
    logic [V:0]       dmag;
    logic [V-1:0]     rem;
    logic [N-1:0]     nq;
    logic [CW-1:0]    count;
    logic             neg, a_neg, b_zero;

    logic [V:0]       rem_shift;
    logic             fits;
    logic [V-1:0]     rem_next;
    fixed_t           q_neg;

    // V+1 bits so that the most-negative operand has a representable magnitude
    function automatic logic [V:0] mag(input fixed_t x);
        logic [V:0] e;
        e = {x[V-1], x};
        return x[V-1] ? (~e + 1'b1) : e;
    endfunction

    // nq shifts numerator bits out of the top while quotient bits enter at the bottom
    assign rem_shift = {rem, nq[N-1]};
    assign fits      = rem_shift >= dmag;
    assign rem_next  = fits ? V'(rem_shift - dmag) : rem_shift[V-1:0];
    assign q_neg     = ~nq[V-1:0] + 1'b1;
    assign ready     = (state == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            done           <= 1'b0;
            quotient       <= '0;
            divide_by_zero <= 1'b0;
            overflow       <= 1'b0;
            pipeline_o     <= '0;
            a_q            <= '0;
            b_q            <= '0;
            tag_q          <= '0;
            dmag           <= '0;
            rem            <= '0;
            nq             <= '0;
            count          <= '0;
            neg            <= 1'b0;
            a_neg          <= 1'b0;
            b_zero         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        tag_q <= pipeline_i;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dmag   <= mag(b_q);
                    nq     <= N'(mag(a_q)) << F;
                    neg    <= a_q[V-1] ^ b_q[V-1];
                    a_neg  <= a_q[V-1];
                    b_zero <= (b_q == '0);
                    rem    <= '0;
                    count  <= CW'(N);
                    state  <= DIVIDE;
                end
                DIVIDE: begin
                    rem   <= rem_next;
                    nq    <= {nq[N-2:0], fits};
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    done       <= 1'b1;
                    pipeline_o <= tag_q;
                    state      <= IDLE;
                    if (b_zero) begin
                        quotient       <= a_neg ? MIN_Q : MAX_Q;
                        divide_by_zero <= 1'b1;
                        overflow       <= 1'b0;
                    end else if (!neg && nq > POS_LIM) begin
                        quotient       <= MAX_Q;
                        divide_by_zero <= 1'b0;
                        overflow       <= 1'b1;
                    end else if (neg && nq > NEG_LIM) begin
                        quotient       <= MIN_Q;
                        divide_by_zero <= 1'b0;
                        overflow       <= 1'b1;
                    end else begin
                        quotient       <= neg ? q_neg : fixed_t'(nq[V-1:0]);
                        divide_by_zero <= 1'b0;
                        overflow       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider (Q16.16): directed corner cases,
// handshake behaviour, mid-operation reset and randomized operands against an arithmetic model.
module tb_fixed_point_divider;
    import ransac_fixed::*;

    typedef logic [7:0] tag_t;
    localparam int LAT = 50;
    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic   clock = 1'b0;
    logic   reset, start, ready, done, divide_by_zero, overflow;
    fixed_t dividend, divisor, quotient;
    tag_t   pipeline_i, pipeline_o;
    int     passed = 0;
    int     total  = 0;

    always #5 clock = ~clock;

    fixed_point_divider #(.external_pipeline(tag_t)) dut (
        .clock(clock), .reset(reset), .start(start), .ready(ready),
        .dividend(dividend), .divisor(divisor), .pipeline_i(pipeline_i),
        .quotient(quotient), .done(done), .divide_by_zero(divide_by_zero),
        .overflow(overflow), .pipeline_o(pipeline_o)
    );

    // Reference: exact integer division of the scaled dividend, truncating toward zero, then saturate
    function automatic void model(input fixed_t a, input fixed_t b,
                                  output fixed_t q, output bit dz, output bit ov);
        longint n, r;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            q  = (a < 0) ? 32'h80000000 : 32'h7FFFFFFF;
            return;
        end
        n = longint'(a) * 64'sd65536;
        r = n / longint'(b);
        if (r > QMAX) begin
            q = 32'h7FFFFFFF; ov = 1'b1;
        end else if (r < QMIN) begin
            q = 32'h80000000; ov = 1'b1;
        end else begin
            q = fixed_t'(r);
        end
    endfunction

    // Drive one accepted request, scramble the inputs afterwards, and count edges until done
    task automatic issue(input fixed_t a, input fixed_t b, input tag_t t, output int lat);
        @(negedge clock);
        dividend = a; divisor = b; pipeline_i = t; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        dividend = fixed_t'($urandom); divisor = fixed_t'($urandom); pipeline_i = tag_t'($urandom);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; pipeline_i = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (quotient !== 32'h0) $display("FAIL reset_quotient got %h want 0", quotient); else passed++;
        total++; if (divide_by_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", divide_by_zero); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
        total++; if (pipeline_o !== 8'h0) $display("FAIL reset_tag got %h want 0", pipeline_o); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        fixed_t ta [11] = '{32'h00060000, 32'hFFF88000, 32'h00010000, 32'hFFFF0000, 32'h00010000,
                            32'hFFFF0000, 32'h40000000, 32'h80000000, 32'h80000000, 32'h00000000,
                            32'h00000000};
        fixed_t tb [11] = '{32'h00020000, 32'h00020000, 32'h00030000, 32'h00030000, 32'h00000000,
                            32'h00000000, 32'h00000001, 32'hFFFF0000, 32'h00010000, 32'h00030000,
                            32'h00000000};
        fixed_t tq [11] = '{32'h00030000, 32'hFFFC4000, 32'h00005555, 32'hFFFFAAAB, 32'h7FFFFFFF,
                            32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                            32'h7FFFFFFF};
        bit tdz [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
        bit tov [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        int lat;
        for (int i = 0; i < 11; i++) begin
            issue(ta[i], tb[i], tag_t'(i + 1), lat);
            total++; if (lat !== LAT) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (quotient !== tq[i]) $display("FAIL dir%0d_quotient got %h want %h", i, quotient, tq[i]); else passed++;
            total++; if (divide_by_zero !== tdz[i]) $display("FAIL dir%0d_dz got %b want %b", i, divide_by_zero, tdz[i]); else passed++;
            total++; if (overflow !== tov[i]) $display("FAIL dir%0d_ovf got %b want %b", i, overflow, tov[i]); else passed++;
            total++; if (pipeline_o !== tag_t'(i + 1)) $display("FAIL dir%0d_tag got %h want %h", i, pipeline_o, tag_t'(i + 1)); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        fixed_t eq; bit edz, eov;
        int lat;
        model(32'h00090000, 32'h00040000, eq, edz, eov);
        @(negedge clock);
        dividend = 32'h00090000; divisor = 32'h00040000; pipeline_i = 8'h33; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == 9) begin
                start = 1'b1; dividend = 32'h00010000; divisor = 32'h00070000; pipeline_i = 8'hEE;
            end
            @(posedge clock); #1;
            lat++;
            start = 1'b0;
        end
        total++; if (lat !== LAT) $display("FAIL ignore_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (quotient !== eq) $display("FAIL ignore_quotient got %h want %h", quotient, eq); else passed++;
        total++; if (pipeline_o !== 8'h33) $display("FAIL ignore_tag got %h want 33", pipeline_o); else passed++;
        // The ignored request must not have been queued behind the first one
        repeat (5) @(posedge clock);
        #1;
        total++; if (ready !== 1'b1) $display("FAIL ignore_idle got ready=%b want 1", ready); else passed++;
    endtask

    task automatic test_back_to_back();
        fixed_t eq; bit edz, eov;
        int lat;
        model(32'hFFF00000, 32'h00030000, eq, edz, eov);
        issue(32'hFFF00000, 32'h00030000, 8'hA5, lat);
        total++; if (quotient !== eq) $display("FAIL b2b_first_quotient got %h want %h", quotient, eq); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL b2b_ready_in_done got %b want 1", ready); else passed++;
        dividend = 32'h00050000; divisor = 32'h00000000; pipeline_i = 8'h5A; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        total++; if (ready !== 1'b0) $display("FAIL b2b_accept got ready=%b want 0", ready); else passed++;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        total++; if (lat !== LAT) $display("FAIL b2b_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (quotient !== 32'h7FFFFFFF) $display("FAIL b2b_quotient got %h want 7fffffff", quotient); else passed++;
        total++; if (divide_by_zero !== 1'b1) $display("FAIL b2b_dz got %b want 1", divide_by_zero); else passed++;
        total++; if (pipeline_o !== 8'h5A) $display("FAIL b2b_tag got %h want 5a", pipeline_o); else passed++;
    endtask

    task automatic test_reset_mid();
        fixed_t eq; bit edz, eov;
        bit saw_done;
        int lat;
        @(negedge clock);
        dividend = 32'h00070000; divisor = 32'h00020000; pipeline_i = 8'h77; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
        total++; if (quotient !== 32'h0) $display("FAIL rstmid_quotient got %h want 0", quotient); else passed++;
        total++; if (divide_by_zero !== 1'b0) $display("FAIL rstmid_dz got %b want 0", divide_by_zero); else passed++;
        total++; if (pipeline_o !== 8'h0) $display("FAIL rstmid_tag got %h want 0", pipeline_o); else passed++;
        @(negedge clock);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", saw_done); else passed++;
        model(32'hFFFD0000, 32'h00040000, eq, edz, eov);
        issue(32'hFFFD0000, 32'h00040000, 8'h42, lat);
        total++; if (lat !== LAT) $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (quotient !== eq) $display("FAIL rstmid_quotient2 got %h want %h", quotient, eq); else passed++;
        total++; if (pipeline_o !== 8'h42) $display("FAIL rstmid_tag2 got %h want 42", pipeline_o); else passed++;
    endtask

    task automatic test_random();
        fixed_t a, b, eq; bit edz, eov;
        tag_t t;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = fixed_t'($urandom);
            if ($urandom_range(0, 1) == 1) a = a >>> $urandom_range(0, 24);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = fixed_t'($urandom);
                default: b = fixed_t'($urandom >> $urandom_range(8, 31));
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            t = tag_t'($urandom);
            model(a, b, eq, edz, eov);
            issue(a, b, t, lat);
            total++; if (lat !== LAT) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (quotient !== eq) $display("FAIL rnd%0d_quotient %h/%h got %h want %h", i, a, b, quotient, eq); else passed++;
            total++; if (divide_by_zero !== edz) $display("FAIL rnd%0d_dz got %b want %b", i, divide_by_zero, edz); else passed++;
            total++; if (overflow !== eov) $display("FAIL rnd%0d_ovf %h/%h got %b want %b", i, a, b, overflow, eov); else passed++;
            total++; if (pipeline_o !== t) $display("FAIL rnd%0d_tag got %h want %h", i, pipeline_o, t); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
